// File: rtl/button_pio_in.sv
// Debounced push-button/switch input PIO with an Avalon-MM register interface.
// Define BUTTON_PIO_IN_EDGE_IRQ_EN to build the EDGECAP/IRQMASK registers and the irq output.
module button_pio_in #(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned TIMEOUT       = 10000,
  parameter int unsigned TIMEOUT_WIDTH = 14,
  parameter string       POLARITY      = "LOW",
  parameter string       EDGE_TYPE     = "ANY"
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic ACTIVE_LOW = (POLARITY == "LOW");
  localparam logic [TIMEOUT_WIDTH-1:0] COUNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [WIDTH-1:0]         logical;
  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [TIMEOUT_WIDTH-1:0] count_q [WIDTH];
  logic [TIMEOUT_WIDTH-1:0] count_d [WIDTH];
  logic [WIDTH-1:0]         irqmask_rd, edgecap_rd;
  logic [31:0]              rdata_mux;
  logic                     unused_bus;

  // Sync flops reset to the idle pin level so release does not look like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= {WIDTH{ACTIVE_LOW}};
      sync2_q <= {WIDTH{ACTIVE_LOW}};
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end

  assign logical = sync2_q ^ {WIDTH{ACTIVE_LOW}};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      count_d[i] = '0;
      if (logical[i] != stable_q[i]) begin
        if (count_q[i] == COUNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          count_d[i] = count_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

`ifdef BUTTON_PIO_IN_EDGE_IRQ_EN
  localparam logic RISE_EN = (EDGE_TYPE != "FALLING");
  localparam logic FALL_EN = (EDGE_TYPE != "RISING");

  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] edge_bits;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] w1c_bits;
  logic             irq_q;

  assign edge_bits = ({WIDTH{RISE_EN}} & stable_q & ~stable_dly_q) |
                     ({WIDTH{FALL_EN}} & ~stable_q & stable_dly_q);

  // A new edge overrides a same-cycle clear so no event is lost.
  always_comb begin
    w1c_bits  = (write && (address == 2'd2)) ? writedata[WIDTH-1:0] : '0;
    edgecap_d = (edgecap_q & ~w1c_bits) | edge_bits;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable_q;
      edgecap_q    <= edgecap_d;
      irq_q        <= |(edgecap_q & irqmask_q);
      if (write && (address == 2'd1)) begin
        irqmask_q <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irqmask_rd = irqmask_q;
  assign edgecap_rd = edgecap_q;
  assign irq        = irq_q;
`else
  assign irqmask_rd = '0;
  assign edgecap_rd = '0;
  assign irq        = 1'b0;
`endif

  // Upper write-data bits (and write itself without edge logic) have no destination.
  assign unused_bus = ^{write, writedata};

  always_comb begin
    rdata_mux = '0;
    unique case (address)
      2'd0: rdata_mux[WIDTH-1:0] = stable_q;
      2'd1: rdata_mux[WIDTH-1:0] = irqmask_rd;
      2'd2: rdata_mux[WIDTH-1:0] = edgecap_rd;
      2'd3: rdata_mux[WIDTH-1:0] = logical;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= rdata_mux;
    end
  end

endmodule
